// File: rtl/matmul_pkg.sv
// Shared types and output formatting for the SRAM-streamed matrix-multiply engine.
package matmul_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDimW  = 8;
  localparam int unsigned DefAccW  = 72;

  // Widest formats sat_fmt handles; callers extend/truncate to their own widths.
  localparam int unsigned MaxAccW  = 256;
  localparam int unsigned MaxDataW = 128;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, FINISH} state_t;

  // acc must already be sign- or zero-extended to MaxAccW according to is_signed.
  function automatic logic [MaxDataW-1:0] sat_fmt(input logic [MaxAccW-1:0] acc,
                                                  input int unsigned     data_w,
                                                  input logic            is_signed,
                                                  input logic            sat);
    logic [MaxAccW-1:0] smax;
    logic [MaxAccW-1:0] smin;
    logic [MaxAccW-1:0] umax;
    smax = (MaxAccW'(1) << (data_w - 1)) - MaxAccW'(1);
    smin = ~smax;
    umax = (MaxAccW'(1) << data_w) - MaxAccW'(1);
    if (!sat) return acc[MaxDataW-1:0];
    if (is_signed) begin
      if ($signed(acc) > $signed(smax)) return smax[MaxDataW-1:0];
      if ($signed(acc) < $signed(smin)) return smin[MaxDataW-1:0];
      return acc[MaxDataW-1:0];
    end
    if (acc > umax) return umax[MaxDataW-1:0];
    return acc[MaxDataW-1:0];
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate slice: signed/unsigned product, registered accumulator, live sum.
module mac_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 72
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W-1:0]    acc_q;
  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [ACC_W-1:0]    prod_ext;

  always_comb begin
    prod_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    prod_ext = is_signed ? {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s}
                         : {{(ACC_W-2*DATA_W){1'b0}}, prod_u};
    sum = acc_q + prod_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/sram_matmul_engine.sv
// C = A x B (or A x B^T) streamed from single-port SRAMs, one C element per K+1 cycles.
module sram_matmul_engine
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DIM_W  = DefDimW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dut_valid,
  output logic              dut_ready,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_b_base,
  input  logic [ADDR_W-1:0] cfg_c_base,
  input  logic              cfg_b_trans,
  input  logic              cfg_signed,
  input  logic              cfg_sat,
  output logic [ADDR_W-1:0] a_read_address,
  input  logic [DATA_W-1:0] a_read_data,
  output logic [ADDR_W-1:0] b_read_address,
  input  logic [DATA_W-1:0] b_read_data,
  output logic              c_write_enable,
  output logic [ADDR_W-1:0] c_write_address,
  output logic [DATA_W-1:0] c_write_data,
  output logic              done
);

  localparam int unsigned PW = ADDR_W + 2 * DIM_W;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, kk_q, kk_d;
  logic [DIM_W-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic              trans_q, trans_d, sgn_q, sgn_d, sat_q, sat_d;
  logic              mac_clr, mac_en;
  logic [ACC_W-1:0]  mac_sum;
  logic [MaxAccW-1:0] sum_ext;

  // base + x*y + z, modulo 2^ADDR_W
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [DIM_W-1:0]  x,
                                                 input logic [DIM_W-1:0]  y,
                                                 input logic [DIM_W-1:0]  z);
    logic [PW-1:0] s;
    s = PW'(base) + PW'(x) * PW'(y) + PW'(z);
    return s[ADDR_W-1:0];
  endfunction

  mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (mac_clr),
    .en       (mac_en),
    .is_signed(sgn_q),
    .a        (a_read_data),
    .b        (b_read_data),
    .sum      (mac_sum)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    kk_d     = kk_q;
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;
    trans_d  = trans_q;
    sgn_d    = sgn_q;
    sat_d    = sat_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    c_write_enable = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dut_valid) begin
          m_d      = cfg_m;
          k_d      = cfg_k;
          n_d      = cfg_n;
          a_base_d = cfg_a_base;
          b_base_d = cfg_b_base;
          c_base_d = cfg_c_base;
          trans_d  = cfg_b_trans;
          sgn_d    = cfg_signed;
          sat_d    = cfg_sat;
          i_d      = '0;
          j_d      = '0;
          kk_d     = '0;
          state_d  = (cfg_m != '0 && cfg_k != '0 && cfg_n != '0) ? MAC : FINISH;
        end
      end
      MAC: begin
        // Data for kk-1 arrives this cycle; kk==0 only clears.
        mac_clr = (kk_q == '0);
        mac_en  = (kk_q != '0);
        if (kk_q == k_q - DIM_W'(1)) begin
          kk_d    = '0;
          state_d = WRITE;
        end else begin
          kk_d = kk_q + DIM_W'(1);
        end
      end
      WRITE: begin
        c_write_enable = 1'b1;
        state_d = MAC;
        if (j_q == n_q - DIM_W'(1)) begin
          j_d = '0;
          if (i_q == m_q - DIM_W'(1)) state_d = FINISH;
          else i_d = i_q + DIM_W'(1);
        end else begin
          j_d = j_q + DIM_W'(1);
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dut_ready       = (state_q == IDLE);
    a_read_address  = lin_addr(a_base_q, i_q, k_q, kk_q);
    b_read_address  = trans_q ? lin_addr(b_base_q, j_q, k_q, kk_q)
                              : lin_addr(b_base_q, kk_q, n_q, j_q);
    c_write_address = lin_addr(c_base_q, i_q, n_q, j_q);
    sum_ext         = sgn_q ? MaxAccW'($signed(mac_sum)) : MaxAccW'(mac_sum);
    c_write_data    = DATA_W'(sat_fmt(sum_ext, DATA_W, sgn_q, sat_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      kk_q     <= '0;
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      trans_q  <= 1'b0;
      sgn_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      kk_q     <= kk_d;
      m_q      <= m_d;
      k_q      <= k_d;
      n_q      <= n_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      trans_q  <= trans_d;
      sgn_q    <= sgn_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_sram_matmul_engine.sv
// Randomised and directed checks of sram_matmul_engine against a plain-arithmetic matrix model.
module tb_sram_matmul_engine;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 16;
  localparam int unsigned DMW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dut_valid;
  logic          dut_ready;
  logic [DMW-1:0] cfg_m, cfg_k, cfg_n;
  logic [AW-1:0] cfg_a_base, cfg_b_base, cfg_c_base;
  logic          cfg_b_trans, cfg_signed, cfg_sat;
  logic [AW-1:0] a_read_address, b_read_address, c_write_address;
  logic [DW-1:0] a_read_data, b_read_data, c_write_data;
  logic          c_write_enable;
  logic          done;

  always #5 clk = ~clk;

  sram_matmul_engine u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dut_valid      (dut_valid),
    .dut_ready      (dut_ready),
    .cfg_m          (cfg_m),
    .cfg_k          (cfg_k),
    .cfg_n          (cfg_n),
    .cfg_a_base     (cfg_a_base),
    .cfg_b_base     (cfg_b_base),
    .cfg_c_base     (cfg_c_base),
    .cfg_b_trans    (cfg_b_trans),
    .cfg_signed     (cfg_signed),
    .cfg_sat        (cfg_sat),
    .a_read_address (a_read_address),
    .a_read_data    (a_read_data),
    .b_read_address (b_read_address),
    .b_read_data    (b_read_data),
    .c_write_enable (c_write_enable),
    .c_write_address(c_write_address),
    .c_write_data   (c_write_data),
    .done           (done)
  );

  logic [DW-1:0] mem_a [0:65535];
  logic [DW-1:0] mem_b [0:65535];

  always @(posedge clk) begin
    a_read_data <= mem_a[a_read_address];
    b_read_data <= mem_b[b_read_address];
  end

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] cap_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_fmt(input logic signed [127:0] s, input logic sg,
                                           input logic st);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    logic [127:0]        r;
    if (sg) begin
      hi = 128'sd2147483647;
      lo = -128'sd2147483648;
    end else begin
      hi = 128'sd4294967295;
      lo = 128'sd0;
    end
    r = s;
    if (st && s > hi) r = hi;
    if (st && s < lo) r = lo;
    return r[DW-1:0];
  endfunction

  // Builds the expected write list (address, data) in row-major order.
  task automatic build_ref(input int m, input int k, input int n, input logic [AW-1:0] ab,
                           input logic [AW-1:0] bb, input logic [AW-1:0] cb, input logic tr,
                           input logic sg, input logic st);
    exp_data_q.delete();
    exp_addr_q.delete();
    if (m * k * n == 0) return;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        logic signed [127:0] s;
        s = '0;
        for (int kk = 0; kk < k; kk++) begin
          logic [DW-1:0] av, bv;
          logic signed [127:0] x, y;
          av = mem_a[AW'(ab + i * k + kk)];
          bv = tr ? mem_b[AW'(bb + j * k + kk)] : mem_b[AW'(bb + kk * n + j)];
          x = sg ? {{96{av[DW-1]}}, av} : {96'b0, av};
          y = sg ? {{96{bv[DW-1]}}, bv} : {96'b0, bv};
          s += x * y;
        end
        exp_addr_q.push_back(AW'(cb + i * n + j));
        exp_data_q.push_back(ref_fmt(s, sg, st));
      end
    end
  endtask

  task automatic run_job(input int m, input int k, input int n, input logic [AW-1:0] ab,
                         input logic [AW-1:0] bb, input logic [AW-1:0] cb, input logic tr,
                         input logic sg, input logic st, input bit noise);
    int lat, cyc, wr;
    bit got_done;
    build_ref(m, k, n, ab, bb, cb, tr, sg, st);
    lat = (m * k * n == 0) ? 1 : m * n * (k + 1) + 1;
    cap_q.delete();
    @(negedge clk);
    cfg_m = DMW'(m); cfg_k = DMW'(k); cfg_n = DMW'(n);
    cfg_a_base = ab; cfg_b_base = bb; cfg_c_base = cb;
    cfg_b_trans = tr; cfg_signed = sg; cfg_sat = st;
    dut_valid = 1'b1;
    cyc = 0; wr = 0; got_done = 0;
    while (!got_done && cyc < lat + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_eq("ready_busy", dut_ready, 1'b0);
      if (c_write_enable) begin
        cap_q.push_back(c_write_data);
        if (wr < exp_data_q.size()) begin
          check_eq("c_addr", c_write_address, exp_addr_q[wr]);
          check_eq("c_data", c_write_data, exp_data_q[wr]);
        end else begin
          check_eq("extra_write", 1'b1, 1'b0);
        end
        wr++;
      end
      if (done) begin
        got_done = 1;
        check_eq("done_cycle", cyc, lat);
      end
      if (noise && !got_done) begin
        dut_valid = 1'($urandom);
        cfg_m = DMW'($urandom); cfg_k = DMW'($urandom); cfg_n = DMW'($urandom);
        cfg_a_base = AW'($urandom); cfg_b_base = AW'($urandom); cfg_c_base = AW'($urandom);
        cfg_b_trans = 1'($urandom); cfg_signed = 1'($urandom); cfg_sat = 1'($urandom);
      end else begin
        dut_valid = 1'b0;
      end
    end
    dut_valid = 1'b0;
    if (!got_done) check_eq("done_timeout", 1'b0, 1'b1);
    check_eq("write_count", wr, exp_data_q.size());
    @(negedge clk);
    check_eq("ready_after", dut_ready, 1'b1);
    check_eq("done_after", done, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    dut_valid = 1'b0;
    cfg_m = '0; cfg_k = '0; cfg_n = '0;
    cfg_a_base = '0; cfg_b_base = '0; cfg_c_base = '0;
    cfg_b_trans = 1'b0; cfg_signed = 1'b0; cfg_sat = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_ready", dut_ready, 1'b1);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_we", c_write_enable, 1'b0);
    check_eq("rst_a_addr", a_read_address, 16'h0);
    check_eq("rst_b_addr", b_read_address, 16'h0);
    check_eq("rst_c_addr", c_write_address, 16'h0);
    reset_n = 1'b1;

    // 2x3 * 3x2 unsigned
    for (int i = 0; i < 6; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(i + 7);
    end
    run_job(2, 3, 2, 16'h0, 16'h0, 16'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("mm_n_count", cap_q.size(), 4);
    for (int i = 0; i < cap_q.size() && i < 4; i++) begin
      logic [DW-1:0] want [4];
      want = '{32'd58, 32'd64, 32'd139, 32'd154};
      check_eq("mm_n_val", cap_q[i], want[i]);
    end

    // Same product with B stored transposed
    mem_b[100] = 7; mem_b[101] = 9;  mem_b[102] = 11;
    mem_b[103] = 8; mem_b[104] = 10; mem_b[105] = 12;
    run_job(2, 3, 2, 16'h0, 16'd100, 16'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("mm_t_count", cap_q.size(), 4);
    for (int i = 0; i < cap_q.size() && i < 4; i++) begin
      logic [DW-1:0] want [4];
      want = '{32'd58, 32'd64, 32'd139, 32'd154};
      check_eq("mm_t_val", cap_q[i], want[i]);
    end

    // Signed 1x2 * 2x1
    mem_a[200] = -32'sd3; mem_a[201] = 32'sd4;
    mem_b[200] = 32'sd5;  mem_b[201] = -32'sd2;
    run_job(1, 2, 1, 16'd200, 16'd200, 16'h10, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("signed_val", (cap_q.size() > 0) ? cap_q[0] : 32'hx, 32'hFFFF_FFE9);

    // Saturation vs truncation
    mem_a[300] = 32'h7FFF_FFFF; mem_b[300] = 32'h7FFF_FFFF;
    run_job(1, 1, 1, 16'd300, 16'd300, 16'h20, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("sat_on", (cap_q.size() > 0) ? cap_q[0] : 32'hx, 32'h7FFF_FFFF);
    run_job(1, 1, 1, 16'd300, 16'd300, 16'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("sat_off", (cap_q.size() > 0) ? cap_q[0] : 32'hx, 32'h0000_0001);

    // Zero dimension with busy-time valid noise
    run_job(3, 0, 2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a 4x4x4 job
    @(negedge clk);
    cfg_m = 4; cfg_k = 4; cfg_n = 4;
    cfg_a_base = 16'h500; cfg_b_base = 16'h600; cfg_c_base = 16'h700;
    cfg_b_trans = 1'b0; cfg_signed = 1'b0; cfg_sat = 1'b0;
    dut_valid = 1'b1;
    @(negedge clk);
    dut_valid = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("pre_rst_busy", dut_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_we", c_write_enable, 1'b0);
    check_eq("mid_rst_ready", dut_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("post_rst_we", c_write_enable, 1'b0);
    end
    mem_a[16'h900] = 2; mem_b[16'h900] = 3;
    run_job(1, 1, 1, 16'h900, 16'h900, 16'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_val", (cap_q.size() > 0) ? cap_q[0] : 32'hx, 32'd6);

    // Random jobs, including address wrap and small/large magnitudes
    for (int t = 0; t < 24; t++) begin
      int m, k, n;
      m = $urandom_range(1, 4);
      k = $urandom_range(0, 5);
      n = $urandom_range(1, 4);
      run_job(m, k, n, AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
